axi_rom_read_arbiter: RTL and testbench

//   Shares the single read-only AXI4-Lite ROM slave between two read masters:

---
 rtl/axi_rom_read_arbiter.sv | 156 +++++++++++++++
 tb/tb_axi_rom_read_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rom_read_arbiter.sv
// Two-master round-robin read arbiter in front of a single AXI4-Lite ROM slave.
// One transaction in flight at a time; out-of-window reads are answered locally with SLVERR.
module axi_rom_read_arbiter #(
    parameter int unsigned ROM_BYTES = 4096,
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s0_araddr,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [31:0] s0_rdata,
    output logic [1:0]  s0_rresp,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    input  logic [31:0] s1_araddr,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [31:0] s1_rdata,
    output logic [1:0]  s1_rresp,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERESP} state_t;

    localparam logic [32:0] WIN_LO = {1'b0, ROM_BASE};
    localparam logic [32:0] WIN_HI = {1'b0, ROM_BASE} + 33'(ROM_BYTES);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic        m_arvalid_q, m_arvalid_d;
    logic [31:0] m_araddr_q, m_araddr_d;

    logic        any_req;
    logic        win;
    logic        idle_open;
    logic [31:0] sel_addr;
    logic [32:0] sel_addr_ext;
    logic        in_win;
    logic        gnt_rready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_code;

    // A tie goes to the master that was not served last.
    always_comb begin
        any_req      = s0_arvalid || s1_arvalid;
        win          = (s0_arvalid && s1_arvalid) ? ~last_q : s1_arvalid;
        idle_open    = (state_q == IDLE) && rst_n;
        s0_arready   = idle_open && s0_arvalid && !win;
        s1_arready   = idle_open && s1_arvalid && win;
        sel_addr     = win ? s1_araddr : s0_araddr;
        sel_addr_ext = {1'b0, sel_addr};
        in_win       = (sel_addr_ext >= WIN_LO) && (sel_addr_ext < WIN_HI);
        gnt_rready   = gnt_q ? s1_rready : s0_rready;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        lat_addr_d  = lat_addr_q;
        m_arvalid_d = m_arvalid_q;
        m_araddr_d  = m_araddr_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d      = win;
                    lat_addr_d = sel_addr;
                    if (in_win) begin
                        state_d     = ADDR;
                        m_arvalid_d = 1'b1;
                        m_araddr_d  = sel_addr;
                    end else begin
                        state_d = ERESP;
                    end
                end
            end
            ADDR: begin
                m_araddr_d = lat_addr_q;
                if (m_arready) begin
                    m_arvalid_d = 1'b0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (m_rvalid && gnt_rready) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            ERESP: begin
                if (gnt_rready) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            lat_addr_q  <= '0;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            lat_addr_q  <= lat_addr_d;
            m_arvalid_q <= m_arvalid_d;
            m_araddr_q  <= m_araddr_d;
        end
    end

    // ROM data is passed straight through; only the granted master sees a response.
    always_comb begin
        resp_valid = ((state_q == DATA) && m_rvalid) || (state_q == ERESP);
        resp_data  = (state_q == ERESP) ? ERR_DATA : ((state_q == DATA) ? m_rdata : 32'h0);
        resp_code  = (state_q == ERESP) ? 2'b10 : 2'b00;
        s0_rvalid  = 1'b0;
        s0_rdata   = '0;
        s0_rresp   = '0;
        s1_rvalid  = 1'b0;
        s1_rdata   = '0;
        s1_rresp   = '0;
        if (gnt_q) begin
            s1_rvalid = resp_valid;
            s1_rdata  = resp_data;
            s1_rresp  = resp_code;
        end else begin
            s0_rvalid = resp_valid;
            s0_rdata  = resp_data;
            s0_rresp  = resp_code;
        end
        m_rready = (state_q == DATA) && gnt_rready;
    end

    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = m_araddr_q;

endmodule

// File: tb/tb_axi_rom_read_arbiter.sv
// Randomized bench for axi_rom_read_arbiter: a transaction-level model of the two masters,
// the round-robin rule and a ROM slave with random latency predicts every cycle's outputs.
module tb_axi_rom_read_arbiter;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    localparam longint      ROM_BASE = 0;
    localparam longint      ROM_SIZE = 4096;

    logic             clk;
    logic             rst_n;
    logic [1:0][31:0] s_araddr;
    logic [1:0]       s_arvalid;
    logic [1:0]       s_arready;
    logic [1:0][31:0] s_rdata;
    logic [1:0][1:0]  s_rresp;
    logic [1:0]       s_rvalid;
    logic [1:0]       s_rready;
    logic [31:0]      m_araddr;
    logic             m_arvalid;
    logic             m_arready;
    logic [31:0]      m_rdata;
    logic             m_rvalid;
    logic             m_rready;

    axi_rom_read_arbiter #(.ROM_BYTES(4096), .ROM_BASE(32'h0), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]),
        .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
        .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]),
        .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cycle  = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          grant_log[$];
    int          grant_cyc[$];
    resp_t       resp_log[$];
    int          rready_mode[2];

    bit          busy, gnt, last, inwin, ar_done;
    logic [31:0] cur_addr;
    int          sl_phase, sl_cnt;
    logic [31:0] sl_addr;

    function automatic logic [31:0] rom_word(logic [31:0] a);
        return 32'hC0DE_0000 | {20'h0, a[11:2], 2'b00};
    endfunction

    function automatic bit in_window(logic [31:0] a);
        longint v;
        v = longint'(a);
        return (v >= ROM_BASE) && (v < ROM_BASE + ROM_SIZE);
    endfunction

    function automatic int qsize(int n);
        return (n == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] qfront(int n);
        return (n == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(int n, logic [31:0] a);
        if (n == 0) q0.push_back(a); else q1.push_back(a);
    endtask

    task automatic qpop(int n);
        if (n == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    // One clock: drive masters and ROM slave at the falling edge, then compare against the model.
    task automatic tick();
        bit         win;
        logic [1:0] exp_ar, exp_rv;
        bit         owned, exp_marv, exp_mrr;
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            s_arvalid[n] = (qsize(n) > 0);
            s_araddr[n]  = s_arvalid[n] ? qfront(n) : $urandom();
            case (rready_mode[n])
                0:       s_rready[n] = 1'b1;
                1:       s_rready[n] = 1'($urandom_range(0, 1));
                default: s_rready[n] = 1'b0;
            endcase
        end
        m_arready = (sl_phase == 1) && (sl_cnt == 0);
        m_rvalid  = (sl_phase == 2) && (sl_cnt == 0);
        m_rdata   = m_rvalid ? rom_word(sl_addr) : $urandom();
        #1;
        cycle++;
        win = (s_arvalid == 2'b11) ? ~last : s_arvalid[1];
        for (int n = 0; n < 2; n++) begin
            exp_ar[n] = !busy && s_arvalid[n] && (win == n[0]);
            owned     = busy && (gnt == n[0]);
            exp_rv[n] = owned && (inwin ? (m_rvalid && ar_done) : 1'b1);
            checks++;
            if (s_arready[n] !== exp_ar[n]) begin
                errors++;
                $display("[TB] FAIL arready%0d cyc %0d: got %b expected %b", n, cycle, s_arready[n], exp_ar[n]);
            end
            checks++;
            if (s_rvalid[n] !== exp_rv[n]) begin
                errors++;
                $display("[TB] FAIL rvalid%0d cyc %0d: got %b expected %b", n, cycle, s_rvalid[n], exp_rv[n]);
            end
            if (!owned) begin
                checks++;
                if (s_rdata[n] !== 32'h0 || s_rresp[n] !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL idle_out%0d cyc %0d: got %h/%b expected 0/00", n, cycle, s_rdata[n], s_rresp[n]);
                end
            end
            if (exp_rv[n]) begin
                checks++;
                if (s_rdata[n] !== (inwin ? rom_word(cur_addr) : ERR_DATA) ||
                    s_rresp[n] !== (inwin ? 2'b00 : 2'b10)) begin
                    errors++;
                    $display("[TB] FAIL rdata%0d cyc %0d: got %h/%b expected %h/%b", n, cycle, s_rdata[n], s_rresp[n],
                             inwin ? rom_word(cur_addr) : ERR_DATA, inwin ? 2'b00 : 2'b10);
                end
            end
        end
        exp_marv = busy && inwin && !ar_done;
        checks++;
        if (m_arvalid !== exp_marv) begin
            errors++;
            $display("[TB] FAIL m_arvalid cyc %0d: got %b expected %b", cycle, m_arvalid, exp_marv);
        end
        if (exp_marv) begin
            checks++;
            if (m_araddr !== cur_addr) begin
                errors++;
                $display("[TB] FAIL m_araddr cyc %0d: got %h expected %h", cycle, m_araddr, cur_addr);
            end
        end
        exp_mrr = busy && inwin && ar_done && s_rready[gnt];
        checks++;
        if (m_rready !== exp_mrr) begin
            errors++;
            $display("[TB] FAIL m_rready cyc %0d: got %b expected %b", cycle, m_rready, exp_mrr);
        end

        if (busy && exp_rv[gnt] && s_rready[gnt]) begin
            resp_log.push_back('{port: int'(gnt), resp: s_rresp[gnt], data: s_rdata[gnt], cyc: cycle});
            busy = 1'b0;
            last = gnt;
        end else if (busy && inwin && !ar_done && m_arready) begin
            ar_done = 1'b1;
        end
        if (exp_ar != 2'b00) begin
            busy     = 1'b1;
            gnt      = win;
            cur_addr = qfront(int'(win));
            inwin    = in_window(cur_addr);
            ar_done  = 1'b0;
            qpop(int'(win));
            grant_log.push_back(int'(win));
            grant_cyc.push_back(cycle);
        end

        case (sl_phase)
            0: if (m_arvalid) begin
                sl_phase = 1;
                sl_cnt   = int'($urandom_range(0, 2));
            end
            1: if (m_arready && m_arvalid) begin
                sl_addr  = m_araddr;
                sl_phase = 2;
                sl_cnt   = int'($urandom_range(0, 3));
            end else if (sl_cnt > 0) begin
                sl_cnt--;
            end
            default: if (m_rvalid && m_rready) sl_phase = 0;
                     else if (sl_cnt > 0) sl_cnt--;
        endcase
    endtask

    task automatic run_until_idle(int budget);
        int n = 0;
        while ((busy || q0.size() > 0 || q1.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (busy || q0.size() > 0 || q1.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got busy=%b pending=%0d expected idle within %0d cycles",
                     busy, q0.size() + q1.size(), budget);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; every output must drop at once.
    task automatic do_reset();
        rst_n     = 1'b0;
        s_arvalid = '0;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        q0.delete();
        q1.delete();
        busy = 0; gnt = 0; last = 1; inwin = 0; ar_done = 0;
        sl_phase = 0; sl_cnt = 0;
        #1;
        checks++;
        if (s_arready !== 2'b00 || s_rvalid !== 2'b00 || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got arready=%b rvalid=%b m_arvalid=%b m_rready=%b expected all 0",
                     s_arready, s_rvalid, m_arvalid, m_rready);
        end
        checks++;
        if (s_rdata[0] !== 32'h0 || s_rdata[1] !== 32'h0 || s_rresp[0] !== 2'b00 ||
            s_rresp[1] !== 2'b00 || m_araddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h %h %b %b %h expected zeros",
                     s_rdata[0], s_rdata[1], s_rresp[0], s_rresp[1], m_araddr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        resp_log.delete();
        rready_mode[0] = 0;
        rready_mode[1] = 0;
        qpush(0, 32'h004);
        run_until_idle(50);
        checks++;
        if (resp_log.size() != 1 || resp_log[0].port != 0 || resp_log[0].data !== 32'hC0DE_0004 ||
            resp_log[0].resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_read: got %0d responses expected one OKAY C0DE0004 on port 0", resp_log.size());
        end
    endtask

    task automatic test_both();
        do_reset();
        grant_log.delete();
        qpush(0, 32'h008);
        qpush(1, 32'h00C);
        run_until_idle(100);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            errors++;
            $display("[TB] FAIL tie_order: got %0d grants first=%0d expected 0 then 1",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            qpush(0, 32'h020 + 32'(4 * i));
            qpush(1, 32'h040 + 32'(4 * i));
        end
        run_until_idle(200);
        checks++;
        if (grant_log.size() != 6) begin
            errors++;
            $display("[TB] FAIL alternation_count: got %0d expected 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grant_log[i] != i % 2) begin
                    errors++;
                    $display("[TB] FAIL alternation[%0d]: got %0d expected %0d", i, grant_log[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_error();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_1000;
        addrs[1] = 32'hFFFF_FFFC;
        addrs[2] = 32'h0000_0FFC;
        for (int i = 0; i < 3; i++) begin
            resp_log.delete();
            qpush(1, addrs[i]);
            run_until_idle(60);
            checks++;
            if (resp_log.size() != 1 || resp_log[0].port != 1 ||
                resp_log[0].resp !== (i < 2 ? 2'b10 : 2'b00) ||
                resp_log[0].data !== (i < 2 ? ERR_DATA : 32'hC0DE_0FFC)) begin
                errors++;
                $display("[TB] FAIL window_%h: got %0d responses resp=%b expected resp %b",
                         addrs[i], resp_log.size(), resp_log.size() > 0 ? resp_log[0].resp : 2'bxx,
                         i < 2 ? 2'b10 : 2'b00);
            end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        grant_log.delete();
        rready_mode[0] = 2;
        qpush(0, 32'h010);
        while (!(busy && ar_done && m_rvalid) && n < 50) begin
            tick();
            n++;
        end
        qpush(1, 32'h014);
        repeat (5) begin
            tick();
            checks++;
            if (s_rvalid[0] !== 1'b1 || s_rdata[0] !== 32'hC0DE_0010 || m_rready !== 1'b0 || s_arready[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: got rvalid=%b rdata=%h m_rready=%b arready1=%b expected 1 C0DE0010 0 0",
                         s_rvalid[0], s_rdata[0], m_rready, s_arready[1]);
            end
        end
        rready_mode[0] = 0;
        run_until_idle(60);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            errors++;
            $display("[TB] FAIL stall_order: got %0d grants expected 0 then 1", grant_log.size());
        end
    endtask

    task automatic test_late_request();
        int n = 0;
        grant_log.delete();
        grant_cyc.delete();
        resp_log.delete();
        qpush(0, 32'h018);
        while (!(busy && ar_done) && n < 50) begin
            tick();
            n++;
        end
        qpush(1, 32'h01C);
        run_until_idle(80);
        checks++;
        if (grant_log.size() != 2 || resp_log.size() != 2 || grant_log[1] != 1 ||
            grant_cyc[1] != resp_log[0].cyc + 1) begin
            errors++;
            $display("[TB] FAIL late_grant: got grant cycle %0d expected %0d",
                     grant_cyc.size() > 1 ? grant_cyc[1] : -1, resp_log.size() > 0 ? resp_log[0].cyc + 1 : -1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        qpush(0, 32'h020);
        while (!(busy && inwin && !ar_done) && n < 50) begin
            tick();
            n++;
        end
        do_reset();
        resp_log.delete();
        qpush(1, 32'h024);
        run_until_idle(60);
        checks++;
        if (resp_log.size() != 1 || resp_log[0].data !== 32'hC0DE_0024 || resp_log[0].resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_addr_reset: got %0d responses expected one C0DE0024", resp_log.size());
        end
        n = 0;
        qpush(0, 32'h028);
        while (!(busy && ar_done) && n < 50) begin
            tick();
            n++;
        end
        do_reset();
        resp_log.delete();
        qpush(0, 32'h02C);
        run_until_idle(60);
        checks++;
        if (resp_log.size() != 1 || resp_log[0].data !== 32'hC0DE_002C || resp_log[0].resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL after_data_reset: got %0d responses expected one C0DE002C", resp_log.size());
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        logic [31:0] a;
        resp_log.delete();
        rready_mode[0] = 1;
        rready_mode[1] = 1;
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 3) == 0 && qsize(n) < 3) begin
                    case ($urandom_range(0, 4))
                        0, 1, 2: a = {20'h0, 10'($urandom()), 2'b00};
                        3:       a = 32'h0000_1000 + {18'h0, 12'($urandom())};
                        default: a = $urandom();
                    endcase
                    qpush(n, a);
                    pushed++;
                end
            end
            tick();
        end
        run_until_idle(500);
        checks++;
        if (resp_log.size() != pushed) begin
            errors++;
            $display("[TB] FAIL random_count: got %0d responses expected %0d", resp_log.size(), pushed);
        end
        rready_mode[0] = 0;
        rready_mode[1] = 0;
    endtask

    initial begin
        rst_n          = 1'b1;
        s_arvalid      = '0;
        s_araddr       = '0;
        s_rready       = '0;
        m_arready      = 1'b0;
        m_rvalid       = 1'b0;
        m_rdata        = '0;
        rready_mode[0] = 0;
        rready_mode[1] = 0;
        #3;
        test_reset();
        test_single();
        test_both();
        test_error();
        test_stall();
        test_late_request();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 2000000");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
